hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline (FD, DX, XM, MW).
- Combines combinational MX/WX/WM bypass selection with load-use stall detection.
- Adds a sequential per-register scoreboard for the multi-cycle mult/div unit: writeback from that unit is out of band, so dependent and WAW instructions stall in FD until it completes.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- NUM_REGS, 32, architectural register count.
- REG_W, 5, register address width; must satisfy 2^REG_W >= NUM_REGS.
- ZERO_REG, 1, 1 = register 0 is hardwired and never forwarded, scoreboarded or stalled on; 0 = treated as a normal register.
- CNT_W, 32, stall performance counter width.

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- fd_rs1 / fd_rs2  in  REG_W each  FD source register addresses.
- fd_rs1_re / fd_rs2_re  in  1 each  FD source read enables.
- fd_rd  in  REG_W  FD destination register.
- fd_we  in  1  FD instruction writes fd_rd.
- dx_rs1 / dx_rs2  in  REG_W each  DX source register addresses.
- dx_rs1_re / dx_rs2_re  in  1 each  DX source read enables.
- dx_rd  in  REG_W  DX destination register.
- dx_we  in  1  DX instruction writes dx_rd.
- dx_is_load  in  1  DX instruction is lw.
- dx_is_md  in  1  DX instruction is mul/div (issues to the multdiv unit).
- flush  in  1  branch/jump taken this cycle; the DX instruction is squashed.
- xm_rd  in  REG_W  XM destination register.
- xm_we  in  1  XM instruction writes xm_rd.
- xm_is_store  in  1  XM instruction is sw.
- xm_st_src  in  REG_W  sw data source register.
- mw_rd  in  REG_W  MW destination register.
- mw_we  in  1  MW instruction writes mw_rd.
- md_done  in  1  one-cycle pulse: the multdiv result is written this cycle.
- md_rd  in  REG_W  destination register of the completing multdiv result.
- fwd_a_sel / fwd_b_sel  out  2 each  ALU operand source: 00 regfile, 01 XM (MX bypass), 10 MW (WX bypass).
- wm_bypass  out  1  store data taken from MW.
- stall_fd  out  1  hold PC and FD; insert a bubble into DX.
- md_busy  out  1  multdiv operation outstanding.
- sb_pending  out  NUM_REGS  scoreboard bit vector.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (reset low, asynchronous):
  - sb_pending = 0, md_busy = 0, stall_cnt = 0.
  - stall_fd forced to 0 while reset is low.
  - fwd_a_sel, fwd_b_sel and wm_bypass stay combinational; with all *_we = 0 they are 00 and 0.
- "Valid match": addresses equal AND the enable is set AND NOT (ZERO_REG=1 and address = 0).
- Forwarding (combinational, zero latency):
  - fwd_a_sel = 01 if dx_rs1 valid-matches xm_rd with xm_we.
  - Otherwise 10 if it valid-matches mw_rd with mw_we.
  - Otherwise 00.
  - MX takes priority over WX. fwd_b_sel is the same using dx_rs2.
  - A DX read of a register whose sb_pending bit is set must never occur, because stall_fd prevents it.
- wm_bypass = xm_is_store AND mw_we AND xm_st_src valid-matches mw_rd.
- stall_fd = OR of:
  - (a) Load-use: dx_is_load AND dx_we AND (fd_rs1 or fd_rs2, with its read enable) valid-matches dx_rd.
  - (b) RAW on scoreboard: a read-enabled FD source has its sb_pending bit set and is not cleared by md_done this same cycle.
  - (c) WAW on scoreboard: fd_we AND sb_pending[fd_rd] set, with the same md_done exception as (b).
  - (d) Structural: FD is an md instruction (decoded as fd_we AND the companion signal dx_is_md in the following cycle) ... simplified rule: md_busy=1 AND dx_is_md=1 holds FD.
- Bubble on stall: the upstream pipeline zeroes the DX controls on the cycle after stall_fd. Also on stall, dx_is_md seen while md_busy=1 is ignored for issue.
- Scoreboard, on rising clock:
  - Issue = dx_is_md AND dx_we AND NOT flush AND NOT md_busy.
  - Issue sets sb_pending[dx_rd] (skipped when ZERO_REG=1 and dx_rd = 0) and sets md_busy.
  - md_done clears sb_pending[md_rd] and clears md_busy.
  - Simultaneous md_done and issue: the clear is applied first, then the set. md_busy ends at 1, and if md_rd = dx_rd the bit ends at 1.
  - md_done with md_busy = 0 is ignored (no state change).
  - flush never clears existing scoreboard bits; only an issue in the flushed cycle is suppressed.
- stall_cnt increments on every cycle with stall_fd = 1 and saturates at all-ones.
- Reset mid-operation: all state clears immediately. A later md_done is ignored because md_busy = 0.

Test Plan:
- add r3 in XM, DX reads rs1=r3 with rs2=r3, MW also wrote r3 -> fwd_a_sel=01, fwd_b_sel=01 (MX priority over WX).
- xm_we=1, xm_rd=0, dx_rs1=0, ZERO_REG=1 -> fwd_a_sel=00. Same stimulus with ZERO_REG=0 -> 01.
- lw r5 in DX, FD reads r5 -> stall_fd=1 for exactly 1 cycle; stall_cnt 0->1.
- mul r7 issues; FD reads r7 on the next 10 cycles; md_done with md_rd=7 on cycle 10 -> stall_fd=1 on cycles 1-9, 0 on cycle 10; sb_pending[7] 1->0; md_busy 1->0.
- mul r4 in DX with flush=1 -> sb_pending stays 0, md_busy stays 0.
- sw in XM with xm_st_src=r9, MW writes r9 -> wm_bypass=1. Assert reset low while sb_pending[9]=1 -> sb_pending=0, md_busy=0, stall_cnt=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the 5-stage pipeline.
// Provides MX/WX/WM bypass selection, load-use stalls, a per-register
// scoreboard for the out-of-band multdiv writeback and a saturating
// stall-cycle counter.
module hazard_forward_unit #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [REG_W-1:0]    fd_rs1,
  input  logic [REG_W-1:0]    fd_rs2,
  input  logic                fd_rs1_re,
  input  logic                fd_rs2_re,
  input  logic [REG_W-1:0]    fd_rd,
  input  logic                fd_we,
  input  logic [REG_W-1:0]    dx_rs1,
  input  logic [REG_W-1:0]    dx_rs2,
  input  logic                dx_rs1_re,
  input  logic                dx_rs2_re,
  input  logic [REG_W-1:0]    dx_rd,
  input  logic                dx_we,
  input  logic                dx_is_load,
  input  logic                dx_is_md,
  input  logic                flush,
  input  logic [REG_W-1:0]    xm_rd,
  input  logic                xm_we,
  input  logic                xm_is_store,
  input  logic [REG_W-1:0]    xm_st_src,
  input  logic [REG_W-1:0]    mw_rd,
  input  logic                mw_we,
  input  logic                md_done,
  input  logic [REG_W-1:0]    md_rd,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                wm_bypass,
  output logic                stall_fd,
  output logic                md_busy,
  output logic [NUM_REGS-1:0] sb_pending,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_XM = 2'b01;
  localparam logic [1:0] SEL_MW = 2'b10;

  logic [NUM_REGS-1:0] sb_pending_q, sb_pending_d;
  logic                md_busy_q, md_busy_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  // Address match that honours the enable and the hardwired zero register.
  function automatic logic vmatch(input logic [REG_W-1:0] a,
                                  input logic [REG_W-1:0] b,
                                  input logic             en);
    return en && (a == b) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Operand bypass selection; the younger XM result wins over MW.
  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (vmatch(dx_rs1, xm_rd, dx_rs1_re && xm_we))      fwd_a_sel = SEL_XM;
    else if (vmatch(dx_rs1, mw_rd, dx_rs1_re && mw_we)) fwd_a_sel = SEL_MW;
    if (vmatch(dx_rs2, xm_rd, dx_rs2_re && xm_we))      fwd_b_sel = SEL_XM;
    else if (vmatch(dx_rs2, mw_rd, dx_rs2_re && mw_we)) fwd_b_sel = SEL_MW;
  end

  assign wm_bypass = xm_is_store && vmatch(xm_st_src, mw_rd, mw_we);

  // A completion only counts while an operation is outstanding.
  logic done_valid;
  logic md_issue;
  assign done_valid = md_done && md_busy_q;
  assign md_issue   = dx_is_md && dx_we && !flush && !md_busy_q;

  // Per-register decode of clears, sets and the pending view that FD sees
  // (a register completing this cycle is already considered written).
  logic [NUM_REGS-1:0] clr_vec, set_vec, pend_eff, rs1_hit, rs2_hit, rd_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [REG_W-1:0] IDX  = REG_W'(gi);
      localparam logic             LIVE = !((ZERO_REG != 0) && (gi == 0));
      assign clr_vec[gi]  = done_valid && (md_rd == IDX);
      assign set_vec[gi]  = md_issue && (dx_rd == IDX) && LIVE;
      assign pend_eff[gi] = sb_pending_q[gi] && !clr_vec[gi] && LIVE;
      assign rs1_hit[gi]  = pend_eff[gi] && fd_rs1_re && (fd_rs1 == IDX);
      assign rs2_hit[gi]  = pend_eff[gi] && fd_rs2_re && (fd_rs2 == IDX);
      assign rd_hit[gi]   = pend_eff[gi] && fd_we && (fd_rd == IDX);
    end
  endgenerate

  logic load_use;
  assign load_use = dx_is_load && dx_we &&
                    (vmatch(fd_rs1, dx_rd, fd_rs1_re) || vmatch(fd_rs2, dx_rd, fd_rs2_re));

  // Stall is held low while reset is asserted.
  assign stall_fd = reset && (load_use || (|rs1_hit) || (|rs2_hit) || (|rd_hit) ||
                              (md_busy_q && dx_is_md));

  // Next-state: completion clears first, then a new issue sets.
  always_comb begin
    sb_pending_d = (sb_pending_q & ~clr_vec) | set_vec;
    md_busy_d    = md_busy_q;
    if (done_valid) md_busy_d = 1'b0;
    if (md_issue)   md_busy_d = 1'b1;
    stall_cnt_d  = stall_cnt_q;
    if (stall_fd && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb_pending_q <= '0;
      md_busy_q    <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      sb_pending_q <= sb_pending_d;
      md_busy_q    <= md_busy_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign sb_pending = sb_pending_q;
  assign md_busy    = md_busy_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model. Two instances: default parameters, and ZERO_REG=0
// with a 4-bit counter so saturation is reachable.
module tb_hazard_forward_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [4:0] fd_rs1, fd_rs2, fd_rd, dx_rs1, dx_rs2, dx_rd;
  logic [4:0] xm_rd, xm_st_src, mw_rd, md_rd;
  logic fd_rs1_re, fd_rs2_re, fd_we, dx_rs1_re, dx_rs2_re, dx_we;
  logic dx_is_load, dx_is_md, flush, xm_we, xm_is_store, mw_we, md_done;

  logic [1:0]  fa0, fa1, fb0, fb1;
  logic        wm0, wm1, st0, st1, bz0, bz1;
  logic [31:0] sb0, sb1;
  logic [3:0]  cnt0;
  logic [31:0] cnt1;

  int n_pass = 0;
  int n_total = 0;

  // Model state per instance (0: ZERO_REG=0/CNT_W=4, 1: defaults).
  bit     pend [2][32];
  bit     busy [2];
  longint cnt  [2];

  always #5 clock = ~clock;

  hazard_forward_unit #(.NUM_REGS(32), .REG_W(5), .ZERO_REG(0), .CNT_W(4)) u0 (
    .clock(clock), .reset(reset),
    .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_rs1_re(fd_rs1_re), .fd_rs2_re(fd_rs2_re),
    .fd_rd(fd_rd), .fd_we(fd_we),
    .dx_rs1(dx_rs1), .dx_rs2(dx_rs2), .dx_rs1_re(dx_rs1_re), .dx_rs2_re(dx_rs2_re),
    .dx_rd(dx_rd), .dx_we(dx_we), .dx_is_load(dx_is_load), .dx_is_md(dx_is_md),
    .flush(flush), .xm_rd(xm_rd), .xm_we(xm_we), .xm_is_store(xm_is_store),
    .xm_st_src(xm_st_src), .mw_rd(mw_rd), .mw_we(mw_we), .md_done(md_done), .md_rd(md_rd),
    .fwd_a_sel(fa0), .fwd_b_sel(fb0), .wm_bypass(wm0), .stall_fd(st0),
    .md_busy(bz0), .sb_pending(sb0), .stall_cnt(cnt0));

  hazard_forward_unit u1 (
    .clock(clock), .reset(reset),
    .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_rs1_re(fd_rs1_re), .fd_rs2_re(fd_rs2_re),
    .fd_rd(fd_rd), .fd_we(fd_we),
    .dx_rs1(dx_rs1), .dx_rs2(dx_rs2), .dx_rs1_re(dx_rs1_re), .dx_rs2_re(dx_rs2_re),
    .dx_rd(dx_rd), .dx_we(dx_we), .dx_is_load(dx_is_load), .dx_is_md(dx_is_md),
    .flush(flush), .xm_rd(xm_rd), .xm_we(xm_we), .xm_is_store(xm_is_store),
    .xm_st_src(xm_st_src), .mw_rd(mw_rd), .mw_we(mw_we), .md_done(md_done), .md_rd(md_rd),
    .fwd_a_sel(fa1), .fwd_b_sel(fb1), .wm_bypass(wm1), .stall_fd(st1),
    .md_busy(bz1), .sb_pending(sb1), .stall_cnt(cnt1));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic bit vm(input bit z, input int a, input int b, input bit en);
    return en && (a == b) && !(z && a == 0);
  endfunction

  function automatic bit pe(input int k, input bit z, input int r, input bit dv);
    return pend[k][r] && !(dv && md_rd == r) && !(z && r == 0);
  endfunction

  function automatic int fsel(input bit z, input int rs, input bit re);
    if (vm(z, rs, xm_rd, re && xm_we)) return 1;
    if (vm(z, rs, mw_rd, re && mw_we)) return 2;
    return 0;
  endfunction

  // Per-cycle comparison against the model, then model advance for the next edge.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      bit z, dv, lu, raw, waw, est, iss;
      longint esb, cmax;
      z = (k == 1);
      cmax = (k == 0) ? 15 : 64'hFFFF_FFFF;
      if (!reset) begin
        for (int r = 0; r < 32; r++) pend[k][r] = 0;
        busy[k] = 0;
        cnt[k] = 0;
      end
      dv  = md_done && busy[k];
      lu  = dx_is_load && dx_we &&
            (vm(z, fd_rs1, dx_rd, fd_rs1_re) || vm(z, fd_rs2, dx_rd, fd_rs2_re));
      raw = (fd_rs1_re && pe(k, z, fd_rs1, dv)) || (fd_rs2_re && pe(k, z, fd_rs2, dv));
      waw = fd_we && pe(k, z, fd_rd, dv);
      est = reset && (lu || raw || waw || (busy[k] && dx_is_md));
      esb = 0;
      for (int r = 0; r < 32; r++) if (pend[k][r]) esb |= (64'd1 << r);
      chk($sformatf("u%0d.fwd_a_sel", k), (k == 0) ? fa0 : fa1, fsel(z, dx_rs1, dx_rs1_re));
      chk($sformatf("u%0d.fwd_b_sel", k), (k == 0) ? fb0 : fb1, fsel(z, dx_rs2, dx_rs2_re));
      chk($sformatf("u%0d.wm_bypass", k), (k == 0) ? wm0 : wm1,
          xm_is_store && vm(z, xm_st_src, mw_rd, mw_we));
      chk($sformatf("u%0d.stall_fd", k), (k == 0) ? st0 : st1, est);
      chk($sformatf("u%0d.md_busy", k), (k == 0) ? bz0 : bz1, busy[k]);
      chk($sformatf("u%0d.sb_pending", k), (k == 0) ? sb0 : sb1, esb);
      chk($sformatf("u%0d.stall_cnt", k), (k == 0) ? longint'(cnt0) : longint'(cnt1), cnt[k]);
      if (reset) begin
        iss = dx_is_md && dx_we && !flush && !busy[k];
        if (dv) begin pend[k][md_rd] = 0; busy[k] = 0; end
        if (iss) begin
          if (!(z && dx_rd == 0)) pend[k][dx_rd] = 1;
          busy[k] = 1;
        end
        if (est && cnt[k] < cmax) cnt[k]++;
      end
    end
  end

  task automatic idle();
    fd_rs1 = 0; fd_rs2 = 0; fd_rd = 0; fd_rs1_re = 0; fd_rs2_re = 0; fd_we = 0;
    dx_rs1 = 0; dx_rs2 = 0; dx_rd = 0; dx_rs1_re = 0; dx_rs2_re = 0; dx_we = 0;
    dx_is_load = 0; dx_is_md = 0; flush = 0;
    xm_rd = 0; xm_we = 0; xm_is_store = 0; xm_st_src = 0;
    mw_rd = 0; mw_we = 0; md_done = 0; md_rd = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [4:0] last_md_rd = 5'd0;

  initial begin
    idle();
    // Reset state, and stall held low during reset even with a load-use pattern.
    dx_is_load = 1; dx_we = 1; dx_rd = 5; fd_rs1 = 5; fd_rs1_re = 1;
    #2;
    chk("reset.sb_pending", sb1, 0);
    chk("reset.md_busy", bz1, 0);
    chk("reset.stall_cnt", cnt1, 0);
    chk("reset.stall_fd", st1, 0);
    step(); step();
    reset = 1; idle();

    // MX priority over WX.
    xm_rd = 3; xm_we = 1; mw_rd = 3; mw_we = 1;
    dx_rs1 = 3; dx_rs2 = 3; dx_rs1_re = 1; dx_rs2_re = 1;
    #1;
    chk("mx_prio.fwd_a", fa1, 1);
    chk("mx_prio.fwd_b", fb1, 1);
    step(); idle();

    // Register zero: hardwired vs normal.
    xm_rd = 0; xm_we = 1; dx_rs1 = 0; dx_rs1_re = 1;
    #1;
    chk("zero_reg1.fwd_a", fa1, 0);
    chk("zero_reg0.fwd_a", fa0, 1);
    step(); idle();

    // Load-use: one stall cycle, then the bubble clears it.
    dx_is_load = 1; dx_we = 1; dx_rd = 5; fd_rs1 = 5; fd_rs1_re = 1;
    #1;
    chk("load_use.stall", st1, 1);
    step(); idle();
    fd_rs1 = 5; fd_rs1_re = 1;
    #1;
    chk("load_use.bubble_stall", st1, 0);
    chk("load_use.stall_cnt", cnt1, 1);
    step(); idle();

    // mul r7 issue, dependent FD read for 10 cycles, completion on cycle 10.
    dx_is_md = 1; dx_we = 1; dx_rd = 7;
    #1;
    chk("mul.issue_stall", st1, 0);
    for (int c = 1; c <= 10; c++) begin
      step(); idle();
      fd_rs1 = 7; fd_rs1_re = 1;
      if (c == 10) begin md_done = 1; md_rd = 7; end
      #1;
      if (c == 1) begin
        chk("mul.sb7_set", sb1, 32'h80);
        chk("mul.busy_set", bz1, 1);
      end
      chk($sformatf("mul.stall_c%0d", c), st1, (c < 10) ? 1 : 0);
    end
    step(); idle();
    #1;
    chk("mul.sb7_clear", sb1, 0);
    chk("mul.busy_clear", bz1, 0);
    chk("mul.stall_cnt", cnt1, 10);

    // Flushed mul never issues.
    dx_is_md = 1; dx_we = 1; dx_rd = 4; flush = 1;
    step(); idle();
    #1;
    chk("flush.sb", sb1, 0);
    chk("flush.busy", bz1, 0);

    // WM bypass, then asynchronous reset while r9 is pending.
    xm_is_store = 1; xm_st_src = 9; mw_we = 1; mw_rd = 9;
    dx_is_md = 1; dx_we = 1; dx_rd = 9;
    #1;
    chk("wm.bypass", wm1, 1);
    step(); idle();
    chk("wm.sb9_set", sb1, 32'h200);
    reset = 0;
    #1;
    chk("async_rst.sb", sb1, 0);
    chk("async_rst.busy", bz1, 0);
    chk("async_rst.cnt", cnt1, 0);
    step(); step();
    reset = 1;
    md_done = 1; md_rd = 9;
    step(); idle();
    #1;
    chk("late_done.busy", bz1, 0);
    chk("late_done.sb", sb1, 0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      fd_rs1 = 5'($urandom_range(0, 7)); fd_rs2 = 5'($urandom_range(0, 7));
      fd_rd  = 5'($urandom_range(0, 7));
      fd_rs1_re = ($urandom_range(0, 9) < 7); fd_rs2_re = ($urandom_range(0, 9) < 5);
      fd_we = ($urandom_range(0, 9) < 6);
      dx_rs1 = 5'($urandom_range(0, 7)); dx_rs2 = 5'($urandom_range(0, 7));
      dx_rd  = 5'($urandom_range(0, 7));
      dx_rs1_re = ($urandom_range(0, 9) < 7); dx_rs2_re = ($urandom_range(0, 9) < 5);
      dx_we = ($urandom_range(0, 9) < 7);
      dx_is_load = ($urandom_range(0, 3) == 0);
      dx_is_md = !dx_is_load && ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      xm_rd = 5'($urandom_range(0, 7)); xm_we = ($urandom_range(0, 1) == 1);
      xm_is_store = ($urandom_range(0, 2) == 0); xm_st_src = 5'($urandom_range(0, 7));
      mw_rd = 5'($urandom_range(0, 7)); mw_we = ($urandom_range(0, 1) == 1);
      md_done = ($urandom_range(0, 4) == 0);
      md_rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 7)) : last_md_rd;
      if (dx_is_md && dx_we && !flush) last_md_rd = dx_rd;
    end
    step(); idle();
    #1;
    chk("sat.cnt0", cnt0, 15);
    step();
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
